// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with a valid/ready direct-load port and an auto-scan mode.
// Scan mode (SCAN state, dwell counter, wrap pulse) is built only when DECODER_SCAN_SCAN_EN is defined.
module decoder_scan #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_idx,
  input  logic [DW-1:0]     dwell,
  output logic [(1<<N)-1:0] out,
  output logic [N-1:0]      idx,
  output logic              wrap
);
  localparam int M = 1 << N;

  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

  state_t         state, state_d;
  logic [N-1:0]   idx_d;
  logic [M-1:0]   out_d;
  logic           accept;

`ifdef DECODER_SCAN_SCAN_EN
  logic [DW-1:0] cnt, cnt_d;
  logic          wrap_d;

  assign in_ready = en & ~mode;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    wrap_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (mode) begin
      if (state != SCAN) begin
        state_d = SCAN;
        idx_d   = '0;
        cnt_d   = '0;
      end else if (cnt >= dwell) begin
        // >= so a dwell lowered mid-step advances immediately instead of wrapping the counter
        cnt_d  = '0;
        idx_d  = idx + N'(1);
        wrap_d = (idx == '1);
      end else begin
        cnt_d = cnt + DW'(1);
      end
    end else if (accept) begin
      state_d = HOLD;
      idx_d   = in_idx;
      cnt_d   = '0;
    end else if (state == SCAN) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      wrap <= wrap_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{mode, dwell};

  assign in_ready = en;
  assign accept   = in_valid & en;
  assign wrap     = 1'b0;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (accept) begin
      state_d = HOLD;
      idx_d   = in_idx;
    end
  end
`endif

  // Decode from next-state values so the one-hot output is itself a flop
  for (genvar i = 0; i < M; i++) begin : g_line
    assign out_d[i] = (state_d != IDLE) && (idx_d == N'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      out   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      out   <= out_d;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Randomized + directed bench for decoder_scan against a behavioural model.
// Scan-mode checks are compiled in only when DECODER_SCAN_SCAN_EN is defined.
module tb_decoder_scan;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int M  = 1 << N;
`ifdef DECODER_SCAN_SCAN_EN
  localparam bit HAS_SCAN = 1'b1;
`else
  localparam bit HAS_SCAN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0, mode = 1'b0, in_valid = 1'b0;
  logic [N-1:0]  in_idx = '0;
  logic [DW-1:0] dwell = '0;
  logic          in_ready;
  logic [M-1:0]  out;
  logic [N-1:0]  idx;
  logic          wrap;

  decoder_scan #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_idx(in_idx), .dwell(dwell),
    .out(out), .idx(idx), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: output on/off, scanning flag, current line, and edges elapsed since scan entry.
  bit m_on, m_scan, m_idx_ok, m_wrap;
  int m_idx, m_t;

  task automatic model_reset();
    m_on = 0; m_scan = 0; m_idx = 0; m_idx_ok = 1; m_wrap = 0; m_t = 0;
  endtask

  task automatic model_edge();
    int step;
    step   = int'(dwell) + 1;
    m_wrap = 0;
    if (!en) begin
      model_reset();
    end else if (HAS_SCAN && mode) begin
      if (!m_scan) begin
        m_scan = 1; m_on = 1; m_t = 0;
      end else begin
        m_t++;
      end
      m_idx    = (m_t / step) % M;
      m_idx_ok = 1;
      m_wrap   = (m_t > 0) && (m_t % (M * step) == 0);
    end else if (in_valid) begin
      m_on = 1; m_scan = 0; m_idx = int'(in_idx); m_idx_ok = 1;
    end else if (m_scan) begin
      m_on = 0; m_scan = 0; m_idx_ok = 0;
    end
  endtask

  task automatic check_outs();
    chk("out", 32'(out), m_on ? (32'd1 << m_idx) : 32'd0);
    if (m_idx_ok) chk("idx", 32'(idx), 32'(m_idx));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    chk("in_ready", 32'(in_ready), HAS_SCAN ? 32'(en & ~mode) : 32'(en));
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  initial begin
    int tbl_idx [5] = '{0, 1, 3, 7, 13};
    int tbl_out [5] = '{32'h0001, 32'h0002, 32'h0008, 32'h0080, 32'h2000};
    int wraps;

    // Reset state, and accepts ignored while reset is held
    #2 rst = 1'b1;
    #1;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    en = 1'b1; mode = 1'b0; in_valid = 1'b1; in_idx = 4'd3;
    @(posedge clk); #1;
    chk("rst_ignore_out", 32'(out), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(negedge clk) rst = 1'b0;

    // Direct accepts on consecutive cycles
    for (int i = 0; i < 5; i++) begin
      in_idx = N'(tbl_idx[i]);
      cyc();
      chk("dir_tbl", 32'(out), 32'(tbl_out[i]));
    end
    in_valid = 1'b0;
    cyc();
    chk("dir_hold", 32'(out), 32'h2000);

    if (HAS_SCAN) begin
      // Full scan, dwell=2: wrap exactly once, 48 edges after entry
      dwell = 8'd2; mode = 1'b1; wraps = 0;
      for (int c = 0; c < 50; c++) begin
        cyc();
        if (wrap) begin
          wraps++;
          chk("wrap_cycle", 32'(c), 32'd48);
        end
      end
      chk("wrap_count", 32'(wraps), 32'd1);

      // Scan exit with same-cycle accept
      en = 1'b0; cyc();
      en = 1'b1; mode = 1'b1; dwell = 8'd0;
      repeat (7) cyc();
      mode = 1'b0; in_valid = 1'b1; in_idx = 4'd5;
      cyc();
      chk("exit_accept_out", 32'(out), 32'h0020);
      chk("exit_accept_wrap", 32'(wrap), 32'd0);
      in_valid = 1'b0;
      cyc();
      chk("exit_hold_out", 32'(out), 32'h0020);

      // Asynchronous reset mid-scan at idx 9
      mode = 1'b1;
      for (int k = 0; k < 40 && !(m_scan && m_idx == 9); k++) cyc();
      chk("reach_idx9", 32'(idx), 32'd9);
      #2 rst = 1'b1;
      #1;
      chk("amid_rst_out", 32'(out), 32'd0);
      chk("amid_rst_idx", 32'(idx), 32'd0);
      chk("amid_rst_wrap", 32'(wrap), 32'd0);
      model_reset();
      @(negedge clk) rst = 1'b0;
      cyc();
      chk("restart_idx", 32'(idx), 32'd0);
      chk("restart_out", 32'(out), 32'd1);

      // Dwell lowered mid-step: advance on next edge, then every 4 edges
      en = 1'b0; cyc();
      en = 1'b1; mode = 1'b1; dwell = 8'd200;
      cyc();
      repeat (150) cyc();
      chk("dw_before", 32'(idx), 32'd0);
      dwell = 8'd3;
      @(posedge clk); #1;
      chk("dw_next", 32'(idx), 32'd1);
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        chk("dw_dwell", 32'(idx), 32'd1);
      end
      @(posedge clk); #1;
      chk("dw_step", 32'(idx), 32'd2);
      en = 1'b0; cyc();
      en = 1'b1;
    end

    // mode=1 with in_valid=1: scans when built in, otherwise a plain accept
    mode = 1'b1; in_valid = 1'b1; in_idx = 4'd2; dwell = 8'd0;
    cyc();
    chk("mode_valid_out", 32'(out), HAS_SCAN ? 32'h0001 : 32'h0004);
    in_valid = 1'b0;
    repeat (3) begin
      cyc();
      if (!HAS_SCAN) chk("noscan_wrap", 32'(wrap), 32'd0);
    end
    en = 1'b0; mode = 1'b0; cyc();

    // Randomized traffic; dwell changes only on cycles that cannot be scan steps
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      in_valid = 1'($urandom_range(0, 1));
      in_idx   = N'($urandom);
      if ((!en || !mode) && $urandom_range(0, 3) == 0) dwell = DW'($urandom_range(0, 4));
      #1;
      chk("rnd_in_ready", 32'(in_ready), HAS_SCAN ? 32'(en & ~mode) : 32'(en));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered N-to-2^N one-hot decoder with a valid/ready load port and an auto-scan mode. Direct mode latches an index and holds its one-hot output. Scan mode walks the one-hot output through all 2^N lines with a programmable dwell time. It sits between control logic and multiplexed loads such as display digit enables, row selects and chip selects, and replaces the purely combinational decoder.

## Interface
- `N`, default 4: index width; legal range 1..8.
- `M`, default `1<<N`: output width; derived localparam, not overridable.
- `DW`, default 8: dwell counter width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  block enable; low forces IDLE.
- `mode`  in  1  0 = direct, 1 = scan.
- `in_valid`  in  1  index offered.
- `in_ready`  out  1  index can be accepted.
- `in_idx`  in  N  index to decode.
- `dwell`  in  DW  cycles per scan step minus one.
- `out`  out  M  registered one-hot output (all zero in IDLE).
- `idx`  out  N  registered index currently driven.
- `wrap`  out  1  one-cycle pulse when scan returns to index 0.

## Operation
- States: IDLE, HOLD, SCAN.
  - IDLE: `out`=0.
  - HOLD: `out`=1<<`idx`.
  - SCAN: `out`=1<<`idx`, advancing.
- `in_ready` = `en` & ~`mode`, combinational.
- Accept: `in_valid` & `in_ready` at a rising edge. The next state is HOLD with `idx`=`in_idx`. This is legal from IDLE or HOLD; a new accept in HOLD replaces the index.
- Any state -> IDLE when `en`=0. `idx` and the dwell counter clear to 0; `wrap`=0.
- IDLE/HOLD -> SCAN when `en`=1 & `mode`=1. Entry sets `idx`=0, `out`=1, dwell counter=0. The held direct index is discarded.
- SCAN -> IDLE when `mode`=0 (with `en`=1). A direct accept is possible in the same cycle, because `in_ready` is already high; if one occurs, the next state is HOLD instead.
- Scan stepping:
  - The dwell counter increments every SCAN cycle.
  - When counter >= `dwell`, the counter resets to 0 and `idx` = (`idx`+1) mod M.
  - The `>=` compare means a `dwell` reduced mid-step takes effect on the next cycle with no long wrap.
- `dwell`=0: `idx` advances every cycle.
- Steps per full scan cycle = M·(`dwell`+1).
- `wrap` is registered high for exactly one cycle, coincident with `idx` becoming 0 from M-1. It is never high outside SCAN.
- `out` is always zero or exactly one bit (one-hot). No glitches: all outputs are registered.

## Timing
- Reset (async assert, sync release): state IDLE, `out`=0, `idx`=0, `wrap`=0, dwell counter=0. `in_ready` follows `en`&~`mode` even during reset; accepts are ignored while `rst`=1.
- Direct latency: 1 cycle. An accept at edge k gives `out`=1<<`in_idx` after edge k.
- Scan entry latency: 1 cycle after `mode` is sampled high.
- Scan exit: `out`=0 one cycle after `mode` is sampled low, unless an accept occurs in the same cycle.
- Reset mid-scan: outputs clear immediately (asynchronous). After release, the block stays IDLE until `mode` or an accept.
- `en` low takes priority over `mode` and `in_valid`. `mode`=1 with `in_valid`=1 never accepts.

## Configuration
- `DECODER_SCAN_SCAN_EN` defined: full behaviour as above.
- `DECODER_SCAN_SCAN_EN` not defined:
  - SCAN state, dwell counter and stepping logic are removed.
  - `mode` and `dwell` are ignored; `in_ready` = `en`.
  - `wrap` is tied to 0.
  - Only IDLE/HOLD remain.

## Test plan
- Reset, then `en`=1, `mode`=0; accept `in_idx` = 0, 1, 3, 7, 13 on consecutive cycles -> `out` = 0x0001, 0x0002, 0x0008, 0x0080, 0x2000, each one cycle after its accept.
- `en`=1, `mode`=1, `dwell`=2, N=4 -> `idx` steps 0..15, each held 3 cycles. `wrap` pulses once at cycle 48 after entry; `in_ready`=0 throughout.
- During scan with `dwell`=0, drop `mode` to 0 while `in_valid`=1, `in_idx`=5 -> next `out`=0x0020, state HOLD, `wrap`=0.
- Assert `rst` mid-scan at `idx`=9 -> `out`=0, `idx`=0, `wrap`=0 without waiting for a clock edge. After release with `mode`=1, scan restarts at `idx`=0.
- During scan with `dwell`=200, counter at 150, change `dwell` to 3 -> `idx` advances on the next cycle, then every 4 cycles.
- Build without `DECODER_SCAN_SCAN_EN`, drive `mode`=1, `in_valid`=1, `in_idx`=2 -> accepted, `out`=0x0004, `wrap` stays 0.
